// File: rtl/pwm_reg_sched_pkg.sv
// -----------------------------------------------------------------------------
// pwm_reg_sched_pkg
// Shared definitions for the PWM register scheduler:
//   - register address map for the five PWM configuration registers
//   - the fade sequencer state encoding
// -----------------------------------------------------------------------------
package pwm_reg_sched_pkg;

   localparam logic [2:0] REG_EN_OUT_LO = 3'd0;
   localparam logic [2:0] REG_EN_OUT_HI = 3'd1;
   localparam logic [2:0] REG_EN_PWM_LO = 3'd2;
   localparam logic [2:0] REG_EN_PWM_HI = 3'd3;
   localparam logic [2:0] REG_DUTY      = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fade_state_t;

endpackage

// File: rtl/pwm_reg_sched_if.sv
// -----------------------------------------------------------------------------
// pwm_reg_sched_if
// Host register-write bus from the SPI peripheral's decoder.
//   wr_valid : one-cycle write strobe. There is no ready: the scheduler
//              always accepts a write on the edge where wr_valid is high, and
//              the written value is visible on the outputs the next cycle.
//   wr_addr  : register address (0..7, only 0..NUM_REGS-1 implemented)
//   wr_data  : write data
// Modports: master (SPI side, drives), slave (scheduler side, receives).
// -----------------------------------------------------------------------------
interface pwm_reg_sched_if;

   logic       wr_valid;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data);
   modport slave  (input  wr_valid, input  wr_addr, input  wr_data);

endinterface

// File: rtl/pwm_fade_step.sv
// -----------------------------------------------------------------------------
// pwm_fade_step
// Combinational saturating step of the duty cycle toward a target.
//   duty      in  8  current duty cycle
//   target    in  8  value being ramped to
//   step      in  8  increment magnitude (caller guarantees non-zero)
//   next_duty out 8  duty moved one step toward target, clamped at target
//   reached   out 1  next_duty equals target
// A 9-bit intermediate catches carry/borrow so the result never wraps past
// the 8-bit range; it clamps to target instead.
// -----------------------------------------------------------------------------
module pwm_fade_step (
   input  logic [7:0] duty,
   input  logic [7:0] target,
   input  logic [7:0] step,
   output logic [7:0] next_duty,
   output logic       reached
);

   logic [8:0] sum;
   logic [8:0] diff;

   always_comb begin
      sum       = {1'b0, duty} + {1'b0, step};
      diff      = {1'b0, duty} - {1'b0, step};
      next_duty = target;
      if (duty < target) begin
         // Upward: min(duty + step, target)
         if (sum < {1'b0, target}) begin
            next_duty = sum[7:0];
         end
      end else if (duty > target) begin
         // Downward: max(duty - step, target); a borrow means we went below 0
         if (!diff[8] && (diff[7:0] > target)) begin
            next_duty = diff[7:0];
         end
      end
      reached = (next_duty == target);
   end

endmodule

// File: rtl/pwm_reg_sched.sv
// -----------------------------------------------------------------------------
// pwm_reg_sched
// Owns the five PWM configuration registers and arbitrates writes between the
// SPI host path and an internal fade sequencer that ramps the duty cycle.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   host             pwm_reg_sched_if.slave host write bus
//   fade_start       start-fade pulse (sampled only in IDLE)
//   fade_target      duty value to ramp to
//   fade_step        duty increment per step (0 behaves as 1)
//   fade_interval    extra wait cycles between steps
//   en_reg_out_7_0 / en_reg_out_15_8 / en_reg_pwm_7_0 / en_reg_pwm_15_8 /
//   pwm_duty_cycle   registers 0..4
//   fade_busy        high in RUN and DONE
//   fade_done        one-cycle pulse (the DONE state) when a fade completes
//   fade_aborted     one-cycle pulse after a host duty write cancels a fade
//   fade_state       current sequencer state, for observation
// Host writes always take priority over the sequencer on the duty register.
// -----------------------------------------------------------------------------
module pwm_reg_sched
   import pwm_reg_sched_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int NUM_REGS = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   pwm_reg_sched_if.slave    host,
   input  logic              fade_start,
   input  logic [7:0]        fade_target,
   input  logic [7:0]        fade_step,
   input  logic [CNT_W-1:0]  fade_interval,
   output logic [7:0]        en_reg_out_7_0,
   output logic [7:0]        en_reg_out_15_8,
   output logic [7:0]        en_reg_pwm_7_0,
   output logic [7:0]        en_reg_pwm_15_8,
   output logic [7:0]        pwm_duty_cycle,
   output logic              fade_busy,
   output logic              fade_done,
   output logic              fade_aborted,
   output fade_state_t       fade_state
);

   // Register bank
   logic [7:0]       reg_out_lo_q;
   logic [7:0]       reg_out_hi_q;
   logic [7:0]       reg_pwm_lo_q;
   logic [7:0]       reg_pwm_hi_q;
   logic [7:0]       duty_q;

   // Sequencer state and latched fade parameters
   fade_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] ivl_q;
   logic [7:0]       tgt_q;
   logic [7:0]       step_q;
   logic             aborted_q;

   // Combinational controls
   logic             addr_ok;
   logic             host_duty_wr;
   logic             latch_params;
   logic             step_we;
   logic             abort_now;
   logic [7:0]       next_duty;
   logic             reached;

   assign addr_ok      = host.wr_valid && ({29'd0, host.wr_addr} < NUM_REGS);
   assign host_duty_wr = addr_ok && (host.wr_addr == REG_DUTY);

   pwm_fade_step u_step (
      .duty      (duty_q),
      .target    (tgt_q),
      .step      (step_q),
      .next_duty (next_duty),
      .reached   (reached)
   );

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      latch_params = 1'b0;
      step_we      = 1'b0;
      abort_now    = 1'b0;
      case (state_q)
         IDLE: begin
            // A coincident host duty write wins; the start is dropped.
            if (fade_start && !host_duty_wr) begin
               latch_params = 1'b1;
               cnt_d        = '0;
               state_d      = (duty_q == fade_target) ? DONE : RUN;
            end
         end
         RUN: begin
            if (host_duty_wr) begin
               abort_now = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end else if (cnt_q == ivl_q) begin
               step_we = 1'b1;
               cnt_d   = '0;
               if (reached) begin
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Sequencer registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ivl_q     <= '0;
         tgt_q     <= 8'h00;
         step_q    <= 8'h01;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         aborted_q <= abort_now;
         if (latch_params) begin
            ivl_q  <= fade_interval;
            tgt_q  <= fade_target;
            // A zero step would never make progress; treat it as 1.
            step_q <= (fade_step == 8'h00) ? 8'h01 : fade_step;
         end
      end
   end

   // Register bank: host writes first, sequencer steps only the duty register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_out_lo_q <= 8'h00;
         reg_out_hi_q <= 8'h00;
         reg_pwm_lo_q <= 8'h00;
         reg_pwm_hi_q <= 8'h00;
         duty_q       <= 8'h00;
      end else begin
         if (addr_ok) begin
            case (host.wr_addr)
               REG_EN_OUT_LO: reg_out_lo_q <= host.wr_data;
               REG_EN_OUT_HI: reg_out_hi_q <= host.wr_data;
               REG_EN_PWM_LO: reg_pwm_lo_q <= host.wr_data;
               REG_EN_PWM_HI: reg_pwm_hi_q <= host.wr_data;
               REG_DUTY:      duty_q       <= host.wr_data;
               default:       ;
            endcase
         end
         if (step_we && !host_duty_wr) begin
            duty_q <= next_duty;
         end
      end
   end

   assign en_reg_out_7_0  = reg_out_lo_q;
   assign en_reg_out_15_8 = reg_out_hi_q;
   assign en_reg_pwm_7_0  = reg_pwm_lo_q;
   assign en_reg_pwm_15_8 = reg_pwm_hi_q;
   assign pwm_duty_cycle  = duty_q;
   assign fade_busy       = (state_q == RUN) || (state_q == DONE);
   assign fade_done       = (state_q == DONE);
   assign fade_aborted    = aborted_q;
   assign fade_state      = state_q;

endmodule

// File: doc/pwm_reg_sched.md
Name: pwm_reg_sched

Overview:
- Owns the five PWM configuration registers: output-enable low/high, PWM-enable low/high, duty cycle.
- Arbitrates writes to them between two requesters:
  - the SPI register-write path (host);
  - an internal fade sequencer that ramps the duty cycle toward a target at a programmed rate.
- Sits between the SPI peripheral's decoded write strobe and the PWM peripheral's register inputs, replacing direct register ownership in the SPI block.

Parameters:
- CNT_W, 16, width of the fade interval counter.
- NUM_REGS, 5, number of implemented register addresses (0..NUM_REGS-1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- wr_valid  in  1  host write strobe, one cycle per write
- wr_addr  in  3  host register address
- wr_data  in  8  host write data
- fade_start  in  1  start-fade pulse
- fade_target  in  8  duty value to ramp to
- fade_step  in  8  duty increment per step
- fade_interval  in  CNT_W  extra wait cycles between steps
- en_reg_out_7_0  out  8  register 0
- en_reg_out_15_8  out  8  register 1
- en_reg_pwm_7_0  out  8  register 2
- en_reg_pwm_15_8  out  8  register 3
- pwm_duty_cycle  out  8  register 4
- fade_busy  out  1  high while the sequencer is in RUN or DONE
- fade_done  out  1  one-cycle pulse when a fade completes
- fade_aborted  out  1  one-cycle pulse when a host duty write cancels a fade

Behaviour:
- Reset: all register outputs 0x00; fade_busy, fade_done, fade_aborted 0; FSM in IDLE; counter 0.
- Host write:
  - wr_valid with wr_addr < NUM_REGS updates that register at the same edge; the new value is visible the next cycle.
  - Addresses 5..7 are ignored, with no side effects.
- FSM states IDLE, RUN, DONE:
  - IDLE + fade_start:
    - Latch target, interval, and step; a step of 0 is latched as 1.
    - If pwm_duty_cycle == fade_target, go to DONE; otherwise go to RUN with counter = 0.
  - RUN: counter increments each cycle. On the edge where counter == latched interval:
    - duty moves one step toward target, saturating exactly at target (no overshoot, no 8-bit wrap);
    - counter returns to 0.
    - If the new duty == target, go to DONE.
  - Timing: with start sampled at edge k, the first update lands at edge k+interval+1, and each later update interval+1 cycles apart.
  - DONE: fade_done = 1 for exactly one cycle, then return to IDLE. fade_busy = 1 in RUN and in DONE.
- Boundary rules:
  - fade_start while in RUN or DONE is ignored. Latched parameters are not re-sampled mid-fade.
  - Host write to addr 4 in RUN: the host value wins, including when a step is due on the same edge. The FSM goes to IDLE, fade_aborted pulses for one cycle, fade_done does not pulse, and the counter clears.
  - Host write to addr 4 coinciding with fade_start in IDLE: the write is applied and fade_start is ignored.
  - Host writes to addrs 0..3 during a fade are applied and do not disturb the fade.
  - Downward ramp: duty = max(duty - step, target). Upward ramp: duty = min(duty + step, target). Compute with a 9-bit intermediate.
  - Reset asserted mid-fade returns to the reset state at the next edge; no done or abort pulse.

Decomposition:
- Shared package holds:
  - register address constants REG_EN_OUT_LO=0, REG_EN_OUT_HI=1, REG_EN_PWM_LO=2, REG_EN_PWM_HI=3, REG_DUTY=4;
  - the FSM state enum {IDLE, RUN, DONE}.
- One sub-module, pwm_fade_step: combinational saturating step toward target (duty, target, step -> next_duty, reached).
- Register bank, arbitration, and FSM stay in pwm_reg_sched.

Test Plan:
- Reset, then host writes addr0=0xFF, addr2=0x0F, addr4=0x80, addr6=0x55 -> the three valid registers hold their values the cycle after each write; all others remain 0x00; addr6 has no effect.
- duty=0, fade_start target=100 step=10 interval=3 -> duty changes every 4 cycles: 10, 20, …, 100. The 10th update lands at start+40, fade_done pulses once in the following cycle, and fade_busy then falls.
- duty=200, target=5, step=64, interval=0 -> duty goes 136, 72, 8, 5 on consecutive cycles, never wrapping below 5, followed by fade_done.
- Fade 0->250 step 1 interval 0, host writes addr4=0x33 on the same edge a step is due -> duty=0x33, fade_aborted pulses once, no fade_done, FSM in IDLE.
- fade_start with target == current duty (0x40) -> no duty change; fade_busy high 1 cycle; fade_done pulses one cycle after start. A second fade_start issued during that cycle is ignored.
- rst_n low for 1 cycle mid-fade -> all outputs 0x00, no pulses; a following fade_start behaves as from clean reset.
